// File: rtl/mat_slot_alloc_ctrl_pkg.sv
// Shared types, widths and the dims-to-size-class decoder for the matrix slot allocator.
package mat_slot_alloc_ctrl_pkg;

  localparam int unsigned NUM_REQ         = 3;
  localparam int unsigned MAX_ROWS        = 5;
  localparam int unsigned MAX_COLS        = 5;
  localparam int unsigned NUM_CLASS       = MAX_ROWS * MAX_COLS;
  localparam int unsigned SLOTS_PER_CLASS = 8;
  localparam int unsigned ID_W            = 8;
  localparam int unsigned ROW_IDX_W       = 3;
  localparam int unsigned COL_IDX_W       = 3;
  localparam int unsigned LIMIT_W         = 4;
  localparam int unsigned PTR_W           = 3;
  localparam int unsigned CLASS_W         = 5;
  localparam int unsigned REQ_IDX_W       = 2;

  localparam logic [LIMIT_W-1:0] DEFAULT_LIMIT = LIMIT_W'(2);

  typedef logic [CLASS_W-1:0] slot_class_t;

  typedef enum logic [1:0] {
    ALLOC_IDLE,
    ALLOC_CALC,
    ALLOC_RESP
  } alloc_state_t;

  typedef struct packed {
    logic        legal;
    slot_class_t cls;
  } class_info_t;

  typedef struct packed {
    logic [REQ_IDX_W-1:0] idx;
    logic [ROW_IDX_W-1:0] rows;
    logic [COL_IDX_W-1:0] cols;
  } alloc_req_t;

  typedef struct packed {
    logic [REQ_IDX_W-1:0] req_idx;
    logic [ID_W-1:0]      id;
    logic                 overwrite;
    logic                 err;
  } alloc_resp_t;

  // Row-major class index; illegal dims map to class 0 with legal cleared.
  function automatic class_info_t dims_to_class(input logic [ROW_IDX_W-1:0] rows,
                                                input logic [COL_IDX_W-1:0] cols);
    class_info_t info;
    info.legal = (rows != '0) && (cols != '0) &&
                 (32'(rows) <= MAX_ROWS) && (32'(cols) <= MAX_COLS);
    info.cls   = info.legal ?
                 (CLASS_W'(rows - 1'b1) * CLASS_W'(MAX_COLS) + CLASS_W'(cols - 1'b1)) : '0;
    return info;
  endfunction

endpackage

// File: rtl/mat_slot_alloc_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at a rotating pointer that moves past each winner.
module mat_slot_alloc_ctrl_rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  int unsigned   idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (en_i && !found && req_i[PW'(idx)]) begin
        grant_o[PW'(idx)] = 1'b1;
        found             = 1'b1;
        ptr_d             = (idx + 1 == N) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (|grant_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mat_slot_alloc_ctrl.sv
// Matrix store slot allocator: arbitrates producers, assigns FIFO-reused slots per size class.
module mat_slot_alloc_ctrl
  import mat_slot_alloc_ctrl_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][ROW_IDX_W-1:0]   req_rows,
  input  logic [NUM_REQ-1:0][COL_IDX_W-1:0]   req_cols,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                resp_valid,
  output logic [REQ_IDX_W-1:0]                resp_req_idx,
  output logic [ID_W-1:0]                     resp_id,
  output logic                                resp_overwrite,
  output logic                                resp_err,
  input  logic                                limit_wr_en,
  input  logic [LIMIT_W-1:0]                  limit_wr_val,
  output logic [LIMIT_W-1:0]                  limit,
  input  logic                                clear_all,
  input  logic [ROW_IDX_W-1:0]                qry_rows,
  input  logic [COL_IDX_W-1:0]                qry_cols,
  output logic [LIMIT_W-1:0]                  qry_count,
  output logic                                busy
);

  alloc_state_t        state_q, state_d;
  alloc_req_t          req_q, req_d;
  alloc_resp_t         resp_q, resp_d;
  logic [NUM_REQ-1:0]  grant;
  logic                arb_en, limit_ok, clr_tables;
  logic                resp_valid_q, busy_q;
  logic [LIMIT_W-1:0]  qry_count_q, limit_q;
  logic [LIMIT_W-1:0]  count_q  [NUM_CLASS];
  logic [PTR_W-1:0]    wr_ptr_q [NUM_CLASS];

  class_info_t         alloc_ci, qry_ci;
  logic [PTR_W-1:0]    alloc_ptr, alloc_ptr_nxt;
  logic [LIMIT_W-1:0]  alloc_cnt;
  logic [ID_W-1:0]     alloc_id;

  // Maintenance commands take the cycle; no grant is offered while they are present.
  assign arb_en     = (state_q == ALLOC_IDLE) && !clear_all && !limit_wr_en;
  assign limit_ok   = (limit_wr_val != '0) && (limit_wr_val <= LIMIT_W'(SLOTS_PER_CLASS));
  assign clr_tables = (state_q == ALLOC_IDLE) && (clear_all || (limit_wr_en && limit_ok));

  mat_slot_alloc_ctrl_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req_valid),
    .en_i    (arb_en),
    .grant_o (grant)
  );

  assign req_ready = grant;

  assign alloc_ci      = dims_to_class(req_q.rows, req_q.cols);
  assign alloc_ptr     = wr_ptr_q[alloc_ci.cls];
  assign alloc_cnt     = count_q[alloc_ci.cls];
  assign alloc_id      = ID_W'(alloc_ci.cls) * ID_W'(SLOTS_PER_CLASS) + ID_W'(alloc_ptr);
  assign alloc_ptr_nxt = (LIMIT_W'(alloc_ptr) + LIMIT_W'(1) == limit_q) ? '0 : alloc_ptr + PTR_W'(1);
  assign qry_ci        = dims_to_class(qry_rows, qry_cols);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    resp_d  = resp_q;
    unique case (state_q)
      ALLOC_IDLE: begin
        if (|grant) begin
          state_d = ALLOC_CALC;
          for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
              req_d.idx  = REQ_IDX_W'(k);
              req_d.rows = req_rows[k];
              req_d.cols = req_cols[k];
            end
          end
        end
      end
      ALLOC_CALC: begin
        state_d          = ALLOC_RESP;
        resp_d.req_idx   = req_q.idx;
        resp_d.id        = alloc_ci.legal ? alloc_id : '0;
        resp_d.overwrite = alloc_ci.legal && (alloc_cnt == limit_q);
        resp_d.err       = !alloc_ci.legal;
      end
      ALLOC_RESP: state_d = ALLOC_IDLE;
      default:    state_d = ALLOC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ALLOC_IDLE;
      req_q        <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      qry_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      resp_q       <= resp_d;
      resp_valid_q <= (state_q == ALLOC_CALC);
      busy_q       <= (state_d != ALLOC_IDLE);
      qry_count_q  <= qry_ci.legal ? count_q[qry_ci.cls] : '0;
    end
  end

  // Per-class occupancy and write pointers; a new limit always restarts every class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit_q <= DEFAULT_LIMIT;
      for (int i = 0; i < int'(NUM_CLASS); i++) begin
        count_q[i]  <= '0;
        wr_ptr_q[i] <= '0;
      end
    end else if (clr_tables) begin
      if (limit_wr_en && limit_ok) limit_q <= limit_wr_val;
      for (int i = 0; i < int'(NUM_CLASS); i++) begin
        count_q[i]  <= '0;
        wr_ptr_q[i] <= '0;
      end
    end else if ((state_q == ALLOC_CALC) && alloc_ci.legal) begin
      if (alloc_cnt < limit_q) count_q[alloc_ci.cls] <= alloc_cnt + LIMIT_W'(1);
      wr_ptr_q[alloc_ci.cls] <= alloc_ptr_nxt;
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_req_idx   = resp_q.req_idx;
  assign resp_id        = resp_q.id;
  assign resp_overwrite = resp_q.overwrite;
  assign resp_err       = resp_q.err;
  assign limit          = limit_q;
  assign qry_count      = qry_count_q;
  assign busy           = busy_q;

endmodule
